f32m_mult_seq: RTL

//  Sequenced multiplier/squarer in GF(3^{2m}) = GF(3^m)[i]/(i^2+1), parametrised in M.
//  - Reuses one f3m_mult core; a registered start/busy/done handshake replaces free-running restart.
//  - MUL: Karatsuba, 3 core products. SQR: 2 core products.
//  - Sits under the pairing/Tate datapath next to f32m_add/f32m_sub/f32m_cubic.

---
 rtl/f32m_mult_seq_pkg.sv | 56 +++++
 rtl/f32m_opsel.sv | 58 +++++
 rtl/f3m_mult.sv | 61 ++++++
 rtl/f32m_mult_seq.sv | 134 +++++++++++++
 4 files changed

// File: rtl/f32m_mult_seq_pkg.sv
// Shared definitions for the GF(3^{2m}) sequenced multiplier slice.
// Contents: field size and reduction trinomial, GF(3) digit encoding,
// operation mode codes, sequencer states and digit-level GF(3) arithmetic.
package f32m_mult_seq_pkg;

   // GF(3^m) base field: f(x) = x^97 + x^12 + 2
   localparam int unsigned F3M_M = 97;
   localparam int unsigned F3M_K = 12;

   // GF(3) digit encoding; 2'b11 is never produced
   localparam logic [1:0] GF3_0 = 2'b00;
   localparam logic [1:0] GF3_1 = 2'b01;
   localparam logic [1:0] GF3_2 = 2'b10;

   // Width of the core-product index k
   localparam int unsigned KW = 2;

   typedef enum logic {
      MODE_MUL = 1'b0,
      MODE_SQR = 1'b1
   } mode_e;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LAUNCH = 3'd1,
      ST_WAIT   = 3'd2,
      ST_STORE  = 3'd3,
      ST_FINISH = 3'd4
   } state_e;

   // x + y mod 3
   function automatic logic [1:0] gf3_add(input logic [1:0] x, input logic [1:0] y);
      logic [2:0] s;
      s = 3'(x) + 3'(y);
      if (s >= 3'd3) s = s - 3'd3;
      return s[1:0];
   endfunction

   // -x mod 3: with this encoding negation swaps the two bits
   function automatic logic [1:0] gf3_neg(input logic [1:0] x);
      return {x[0], x[1]};
   endfunction

   // x - y mod 3
   function automatic logic [1:0] gf3_sub(input logic [1:0] x, input logic [1:0] y);
      return gf3_add(x, gf3_neg(y));
   endfunction

   // x * y mod 3
   function automatic logic [1:0] gf3_mul(input logic [1:0] x, input logic [1:0] y);
      if (x == GF3_0 || y == GF3_0) return GF3_0;
      else if (x == y)              return GF3_1;
      else                          return GF3_2;
   endfunction

endpackage

// File: rtl/f32m_opsel.sv
// Operand pair selector for the sequenced GF(3^{2m}) multiplier.
// Combinational: picks the core operand pair for product index k.
//   MUL: k0 (a0,b0), k1 (a1,b1), k2 (a0+a1, b0+b1)
//   SQR: k0 (a0+a1, a0-a1), k1 (a0,a1)
// Ports: mode, k, a/b ({x1,x0}, 4M bits), in1_c/in2_c (core operands, 2M bits).
module f32m_opsel
   import f32m_mult_seq_pkg::*;
#(
   parameter int unsigned M = F3M_M
) (
   input  mode_e           mode,
   input  logic [KW-1:0]   k,
   input  logic [4*M-1:0]  a,
   input  logic [4*M-1:0]  b,
   output logic [2*M-1:0]  in1_c,
   output logic [2*M-1:0]  in2_c
);

   localparam int unsigned EW = 2 * M;

   logic [1:0] a0d, a1d, b0d, b1d, x, y;

   // Digit-wise pair mux; sums/differences are carry-free mod 3
   always_comb begin
      in1_c = '0;
      in2_c = '0;
      a0d   = GF3_0;
      a1d   = GF3_0;
      b0d   = GF3_0;
      b1d   = GF3_0;
      x     = GF3_0;
      y     = GF3_0;
      for (int unsigned i = 0; i < M; i++) begin
         a0d = a[2*i +: 2];
         a1d = a[EW + 2*i +: 2];
         b0d = b[2*i +: 2];
         b1d = b[EW + 2*i +: 2];
         if (mode == MODE_SQR) begin
            if (k == KW'(0)) begin
               x = gf3_add(a0d, a1d);
               y = gf3_sub(a0d, a1d);
            end else begin
               x = a0d;
               y = a1d;
            end
         end else begin
            case (k)
               KW'(0):  begin x = a0d; y = b0d; end
               KW'(1):  begin x = a1d; y = b1d; end
               default: begin x = gf3_add(a0d, a1d); y = gf3_add(b0d, b1d); end
            endcase
         end
         in1_c[2*i +: 2] = x;
         in2_c[2*i +: 2] = y;
      end
   end

endmodule

// File: rtl/f3m_mult.sv
// GF(3^m) digit-serial multiplier core, MSB-first Horner over b.
// While reset is high the operands are loaded and the accumulator cleared;
// after reset falls one digit of b is consumed per cycle and done rises
// with the final product after M cycles. Result and done hold until reset.
// Ports: clk, reset (sync, active-high, also restarts), a, b (EW bits each),
//        c (product, EW bits), done (level, high once c is final).
module f3m_mult
   import f32m_mult_seq_pkg::*;
#(
   parameter int unsigned M = F3M_M,
   parameter int unsigned K = F3M_K
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [2*M-1:0]  a,
   input  logic [2*M-1:0]  b,
   output logic [2*M-1:0]  c,
   output logic            done
);

   localparam int unsigned EW = 2 * M;
   localparam int unsigned CW = $clog2(M);

   logic [EW-1:0] a_q;
   logic [EW-1:0] b_sh;
   logic [CW-1:0] cnt;
   logic [EW-1:0] sh_c;
   logic [EW-1:0] nxt_c;
   logic [1:0]    top_c;
   logic [1:0]    bd_c;

   // acc' = acc*x mod f + b_digit*a ; x^M folds back as 2x^K + 1
   always_comb begin
      top_c          = c[EW-1 -: 2];
      bd_c           = b_sh[EW-1 -: 2];
      sh_c           = {c[EW-3:0], 2'b00};
      sh_c[1:0]      = top_c;
      sh_c[2*K +: 2] = gf3_add(sh_c[2*K +: 2], gf3_neg(top_c));
      nxt_c          = '0;
      for (int unsigned i = 0; i < M; i++) begin
         nxt_c[2*i +: 2] = gf3_add(sh_c[2*i +: 2], gf3_mul(bd_c, a_q[2*i +: 2]));
      end
   end

   // Load on reset, then iterate M times and hold
   always_ff @(posedge clk) begin
      if (reset) begin
         c    <= '0;
         cnt  <= '0;
         done <= 1'b0;
         a_q  <= a;
         b_sh <= b;
      end else if (!done) begin
         c    <= nxt_c;
         b_sh <= {b_sh[EW-3:0], 2'b00};
         cnt  <= cnt + CW'(1);
         if (cnt == CW'(M - 1)) done <= 1'b1;
      end
   end

endmodule

// File: rtl/f32m_mult_seq.sv
// Sequenced multiplier/squarer in GF(3^{2m}) = GF(3^m)[i]/(i^2+1).
// One shared f3m_mult core is run 3 times (MUL, Karatsuba) or 2 times (SQR);
// partial products are kept in p0..p2 and combined on the FINISH cycle.
// Ports: clk, reset (sync, active-high), start (taken when not busy),
//        mode (0=MUL, 1=SQR), a/b ({x1,x0}, 4M bits), c (result, held),
//        busy (operation in flight), done (one-cycle pulse, c valid).
module f32m_mult_seq
   import f32m_mult_seq_pkg::*;
#(
   parameter int unsigned M = F3M_M
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic            mode,
   input  logic [4*M-1:0]  a,
   input  logic [4*M-1:0]  b,
   output logic [4*M-1:0]  c,
   output logic            busy,
   output logic            done
);

   localparam int unsigned EW = 2 * M;
   localparam int unsigned OW = 4 * M;

   state_e        state;
   mode_e         mode_q;
   logic [OW-1:0] a_q;
   logic [OW-1:0] b_q;
   logic [KW-1:0] k;
   logic [EW-1:0] p0, p1, p2;

   logic [EW-1:0] in1_c, in2_c;
   logic [EW-1:0] core_c;
   logic          core_done;
   logic          core_rst_c;
   logic [KW-1:0] last_k_c;
   logic [EW-1:0] c0_c, c1_c;

   f32m_opsel #(.M(M)) u_opsel (
      .mode  (mode_q),
      .k     (k),
      .a     (a_q),
      .b     (b_q),
      .in1_c (in1_c),
      .in2_c (in2_c)
   );

   // Core is held in reset while idle and restarted on every LAUNCH
   assign core_rst_c = reset || (state == ST_IDLE) || (state == ST_LAUNCH);

   f3m_mult #(.M(M), .K(F3M_K)) u_core (
      .clk   (clk),
      .reset (core_rst_c),
      .a     (in1_c),
      .b     (in2_c),
      .c     (core_c),
      .done  (core_done)
   );

   assign last_k_c = (mode_q == MODE_SQR) ? KW'(1) : KW'(2);

   // Output combine: MUL c0=p0-p1, c1=p2-p0-p1 ; SQR c0=p0, c1=-p1
   always_comb begin
      c0_c = '0;
      c1_c = '0;
      for (int unsigned i = 0; i < M; i++) begin
         if (mode_q == MODE_SQR) begin
            c0_c[2*i +: 2] = p0[2*i +: 2];
            c1_c[2*i +: 2] = gf3_neg(p1[2*i +: 2]);
         end else begin
            c0_c[2*i +: 2] = gf3_sub(p0[2*i +: 2], p1[2*i +: 2]);
            c1_c[2*i +: 2] = gf3_sub(gf3_sub(p2[2*i +: 2], p0[2*i +: 2]), p1[2*i +: 2]);
         end
      end
   end

   // Sequencer with registered busy/done/c
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= ST_IDLE;
         mode_q <= MODE_MUL;
         a_q    <= '0;
         b_q    <= '0;
         k      <= '0;
         p0     <= '0;
         p1     <= '0;
         p2     <= '0;
         c      <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  a_q    <= a;
                  b_q    <= b;
                  mode_q <= mode_e'(mode);
                  k      <= '0;
                  busy   <= 1'b1;
                  state  <= ST_LAUNCH;
               end
            end
            ST_LAUNCH: state <= ST_WAIT;
            ST_WAIT: begin
               if (core_done) state <= ST_STORE;
            end
            ST_STORE: begin
               case (k)
                  KW'(0):  p0 <= core_c;
                  KW'(1):  p1 <= core_c;
                  default: p2 <= core_c;
               endcase
               if (k == last_k_c) begin
                  state <= ST_FINISH;
               end else begin
                  k     <= k + KW'(1);
                  state <= ST_LAUNCH;
               end
            end
            ST_FINISH: begin
               c     <= {c1_c, c0_c};
               done  <= 1'b1;
               busy  <= 1'b0;
               k     <= '0;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
